dbg_master: RTL and testbench



---
 rtl/dbg_master_if.sv | 26 ++
 rtl/dbg_master.sv | 187 ++++++++++++++++++
 tb/tb_dbg_master.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_master_if.sv
// Byte-stream and system-bus signal bundle for the dbg_master debug initiator.
// The master modport is the dbg_master side; slave is the host/bus environment side.
interface dbg_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_stb;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_din;
    logic [31:0] bus_dout;
    logic        bus_ack;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_din, bus_ack,
        output rx_ready, tx_data, tx_valid, bus_stb, bus_we, bus_addr, bus_dout
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_din, bus_ack,
        input  rx_ready, tx_data, tx_valid, bus_stb, bus_we, bus_addr, bus_dout
    );
endinterface

// File: rtl/dbg_master.sv
// Debug bus initiator: host byte commands (W/R/N) become single-word ECO32 bus cycles.
// Optional bus timeout is compiled in with macro DBG_MASTER_TIMEOUT_EN.
module dbg_master #(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    dbg_master_if.master  dbg
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, RDAT} state_t;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_N   = 8'h4E;
    localparam logic [7:0] ST_OK   = 8'h2B;
    localparam logic [7:0] ST_BAD  = 8'h3F;
    localparam logic [7:0] ST_TOUT = 8'h21;

    state_t      state, state_next;
    logic [1:0]  cnt;
    logic        is_write;
    logic        read_ok;
    logic [7:0]  status;
    logic [31:0] addr_sr;
    logic [23:0] data_sr;
    logic [31:0] last_addr;
    logic [31:0] rdata;
    logic        rx_ready_q;
    logic        ready_next;
    logic        stb_q, we_q;
    logic [29:0] addr_q;
    logic [31:0] dout_q;
    logic [7:0]  tx_data_c;

    logic        rx_fire, tx_fire, ack_hit, timed_out;
    logic [31:0] addr_full, data_full, next_addr;

    assign rx_fire   = dbg.rx_valid && rx_ready_q;
    assign tx_fire   = dbg.tx_ready && (state == RESP || state == RDAT);
    assign ack_hit   = stb_q && dbg.bus_ack;
    assign addr_full = {addr_sr[23:0], dbg.rx_data};
    assign data_full = {data_sr, dbg.rx_data};
    assign next_addr = last_addr + 32'd4;

`ifdef DBG_MASTER_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Counter holds 0 while the strobe is low, so it starts at 0 on every new cycle.
    always_ff @(posedge clk) begin
        if (rst || !stb_q)
            to_cnt <= '0;
        else if (!dbg.bus_ack)
            to_cnt <= to_cnt + 32'd1;
    end

    assign timed_out = stb_q && !dbg.bus_ack && (to_cnt == 32'(TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rx_fire) begin
                if (dbg.rx_data == CMD_W || dbg.rx_data == CMD_R)
                    state_next = ADDR;
                else if (dbg.rx_data == CMD_N)
                    state_next = BUS;
                else
                    state_next = RESP;
            end
            ADDR: if (rx_fire && cnt == 2'd3)
                state_next = is_write ? DATA : BUS;
            DATA: if (rx_fire && cnt == 2'd3)
                state_next = BUS;
            BUS:  if (ack_hit || timed_out)
                state_next = RESP;
            RESP: if (tx_fire)
                state_next = read_ok ? RDAT : IDLE;
            RDAT: if (tx_fire && cnt == 2'd3)
                state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready_next = (state_next == IDLE) || (state_next == ADDR) || (state_next == DATA);

    always_comb begin
        tx_data_c = 8'h00;
        if (state == RESP)
            tx_data_c = status;
        else if (state == RDAT) begin
            case (cnt)
                2'd0:    tx_data_c = rdata[31:24];
                2'd1:    tx_data_c = rdata[23:16];
                2'd2:    tx_data_c = rdata[15:8];
                default: tx_data_c = rdata[7:0];
            endcase
        end
    end

    // Operand assembly and bus strobe; bus fields only change when a new cycle is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            is_write   <= 1'b0;
            read_ok    <= 1'b0;
            status     <= '0;
            addr_sr    <= '0;
            data_sr    <= '0;
            last_addr  <= '0;
            rdata      <= '0;
            rx_ready_q <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
        end else begin
            rx_ready_q <= ready_next;
            case (state)
                IDLE: if (rx_fire) begin
                    cnt      <= '0;
                    is_write <= (dbg.rx_data == CMD_W);
                    read_ok  <= 1'b0;
                    status   <= ST_BAD;
                    if (dbg.rx_data == CMD_N) begin
                        stb_q     <= 1'b1;
                        we_q      <= 1'b0;
                        addr_q    <= next_addr[31:2];
                        last_addr <= next_addr;
                    end
                end
                ADDR: if (rx_fire) begin
                    addr_sr <= addr_full;
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3 && !is_write) begin
                        stb_q     <= 1'b1;
                        we_q      <= 1'b0;
                        addr_q    <= addr_full[31:2];
                        last_addr <= addr_full;
                    end
                end
                DATA: if (rx_fire) begin
                    data_sr <= data_full[23:0];
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        stb_q     <= 1'b1;
                        we_q      <= 1'b1;
                        addr_q    <= addr_sr[31:2];
                        dout_q    <= data_full;
                        last_addr <= addr_sr;
                    end
                end
                BUS: if (ack_hit) begin
                    stb_q   <= 1'b0;
                    rdata   <= dbg.bus_din;
                    status  <= ST_OK;
                    read_ok <= !is_write;
                end else if (timed_out) begin
                    stb_q   <= 1'b0;
                    status  <= ST_TOUT;
                    read_ok <= 1'b0;
                end
                RESP: if (tx_fire)
                    cnt <= '0;
                RDAT: if (tx_fire)
                    cnt <= cnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign dbg.rx_ready = rx_ready_q;
    assign dbg.tx_valid = (state == RESP) || (state == RDAT);
    assign dbg.tx_data  = tx_data_c;
    assign dbg.bus_stb  = stb_q;
    assign dbg.bus_we   = we_q;
    assign dbg.bus_addr = addr_q;
    assign dbg.bus_dout = dout_q;
endmodule

// File: tb/tb_dbg_master.sv
// Directed self-checking bench for dbg_master: commands, bus timing, backpressure and reset.
module tb_dbg_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    dbg_master_if dif ();

    dbg_master #(.TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .dbg (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        dif.rx_valid = 1'b1;
        dif.rx_data  = b;
        while (!dif.rx_ready && t < 50) begin
            step();
            t++;
        end
        check("rx_ready_wait", dif.rx_ready, 1'b1);
        step();
        dif.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int t = 0;
        dif.tx_ready = 1'b1;
        while (!dif.tx_valid && t < 50) begin
            step();
            t++;
        end
        check({tag, "_valid"}, dif.tx_valid, 1'b1);
        check(tag, dif.tx_data, exp);
        step();
    endtask

    // Serves one bus cycle, raising ack on stb-high cycle ack_at (0 = never ack).
    task automatic do_bus(input string tag, input int ack_at, input logic [31:0] din,
                          input logic we_exp, input logic [29:0] addr_exp,
                          input logic [31:0] dout_exp, input int cyc_exp);
        int cyc = 0;
        bit stable = 1'b1;
        check({tag, "_stb_start"}, dif.bus_stb, 1'b1);
        check({tag, "_we"}, dif.bus_we, we_exp);
        check({tag, "_addr"}, dif.bus_addr, addr_exp);
        if (we_exp) check({tag, "_dout"}, dif.bus_dout, dout_exp);
        while (dif.bus_stb && cyc < 600) begin
            cyc++;
            if (dif.bus_we !== we_exp || dif.bus_addr !== addr_exp ||
                (we_exp && dif.bus_dout !== dout_exp))
                stable = 1'b0;
            if (cyc == ack_at) begin
                dif.bus_ack = 1'b1;
                dif.bus_din = din;
            end
            step();
            dif.bus_ack = 1'b0;
            dif.bus_din = 32'h5A5A_5A5A;
        end
        check({tag, "_stable"}, stable, 1'b1);
        check({tag, "_stb_cycles"}, cyc, cyc_exp);
        check({tag, "_stb_low"}, dif.bus_stb, 1'b0);
        check({tag, "_resp_valid"}, dif.tx_valid, 1'b1);
    endtask

    task automatic recv_word(input string tag, input logic [31:0] w);
        recv_byte({tag, "_d0"}, w[31:24]);
        recv_byte({tag, "_d1"}, w[23:16]);
        recv_byte({tag, "_d2"}, w[15:8]);
        recv_byte({tag, "_d3"}, w[7:0]);
        check({tag, "_done"}, dif.tx_valid, 1'b0);
    endtask

    initial begin
        dif.rx_valid = 1'b0;
        dif.rx_data  = 8'h00;
        dif.tx_ready = 1'b1;
        dif.bus_ack  = 1'b0;
        dif.bus_din  = 32'h0;

        // Reset values
        repeat (3) step();
        check("rst_stb", dif.bus_stb, 1'b0);
        check("rst_we", dif.bus_we, 1'b0);
        check("rst_addr", dif.bus_addr, 30'h0);
        check("rst_dout", dif.bus_dout, 32'h0);
        check("rst_tx_valid", dif.tx_valid, 1'b0);
        check("rst_tx_data", dif.tx_data, 8'h00);
        check("rst_rx_ready", dif.rx_ready, 1'b0);
        rst = 1'b0;
        step();
        check("rx_ready_after_rst", dif.rx_ready, 1'b1);

        // Stray ack while idle must be ignored
        dif.bus_ack = 1'b1;
        step();
        dif.bus_ack = 1'b0;
        step();
        check("stray_ack_tx", dif.tx_valid, 1'b0);
        check("stray_ack_stb", dif.bus_stb, 1'b0);

        // N right after reset reads 0x00000004
        send_byte(8'h4E);
        do_bus("n_first", 1, 32'h0BAD_F00D, 1'b0, 30'h0000_0001, 32'h0, 1);
        recv_byte("n_first_st", 8'h2B);
        recv_word("n_first", 32'h0BAD_F00D);

        // Write with ack on the third strobe cycle
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        do_bus("wr", 3, 32'h0, 1'b1, 30'h0000_0400, 32'hDEAD_BEEF, 3);
        recv_byte("wr_st", 8'h2B);
        check("wr_no_data", dif.tx_valid, 1'b0);

        // Read then next
        send_byte(8'h52);
        send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        do_bus("rd", 1, 32'h1234_5678, 1'b0, 30'h0C00_0002, 32'h0, 1);
        recv_byte("rd_st", 8'h2B);
        recv_word("rd", 32'h1234_5678);
        send_byte(8'h4E);
        do_bus("nx", 2, 32'hCAFE_F00D, 1'b0, 30'h0C00_0003, 32'h0, 2);
        recv_byte("nx_st", 8'h2B);
        recv_word("nx", 32'hCAFE_F00D);

        // Unknown command
        send_byte(8'h41);
        check("unk_stb", dif.bus_stb, 1'b0);
        recv_byte("unk_st", 8'h3F);
        check("unk_no_data", dif.tx_valid, 1'b0);
        check("unk_stb_after", dif.bus_stb, 1'b0);

        // Next-read wrap
        send_byte(8'h52);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFC);
        do_bus("wrap_r", 1, 32'h0102_0304, 1'b0, 30'h3FFF_FFFF, 32'h0, 1);
        recv_byte("wrap_r_st", 8'h2B);
        recv_word("wrap_r", 32'h0102_0304);
        send_byte(8'h4E);
        do_bus("wrap_n", 1, 32'h99AA_BBCC, 1'b0, 30'h0000_0000, 32'h0, 1);
        recv_byte("wrap_n_st", 8'h2B);
        recv_word("wrap_n", 32'h99AA_BBCC);

        // Backpressure during read data
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        do_bus("bp", 1, 32'hA1B2_C3D4, 1'b0, 30'h0000_0008, 32'h0, 1);
        recv_byte("bp_st", 8'h2B);
        dif.tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", dif.tx_valid, 1'b1);
            check("bp_hold_data", dif.tx_data, 8'hA1);
            step();
        end
        recv_word("bp", 32'hA1B2_C3D4);

        // Reset in the middle of a command
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00);
        rst = 1'b1;
        step();
        check("mid_rst_rx_ready", dif.rx_ready, 1'b0);
        check("mid_rst_stb", dif.bus_stb, 1'b0);
        step();
        check("mid_rst_rx_ready2", dif.rx_ready, 1'b0);
        check("mid_rst_tx_valid", dif.tx_valid, 1'b0);
        rst = 1'b0;
        step();
        check("post_rst_rx_ready", dif.rx_ready, 1'b1);
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        do_bus("post_rst_wr", 1, 32'h0, 1'b1, 30'h0000_0010, 32'h1122_3344, 1);
        recv_byte("post_rst_wr_st", 8'h2B);
        check("post_rst_wr_done", dif.tx_valid, 1'b0);

        // Slow ack: timeout behaviour depends on the build
`ifdef DBG_MASTER_TIMEOUT_EN
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        do_bus("tout", 0, 32'h0, 1'b0, 30'h0000_0040, 32'h0, 256);
        recv_byte("tout_st", 8'h21);
        check("tout_no_data", dif.tx_valid, 1'b0);
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        do_bus("late_ack", 256, 32'h7E57_0256, 1'b0, 30'h0000_0040, 32'h0, 256);
        recv_byte("late_ack_st", 8'h2B);
        recv_word("late_ack", 32'h7E57_0256);
`else
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        do_bus("slow_ack", 300, 32'h5105_0300, 1'b0, 30'h0000_0040, 32'h0, 300);
        recv_byte("slow_ack_st", 8'h2B);
        recv_word("slow_ack", 32'h5105_0300);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
